serial_digit_collector: RTL and testbench

Downstream stage of the serial code-converter FSM. Consumes the converter's serial data bit and per-bit error flag, reassembles each 4-bit digit LSB-first, tags it with an error bit, and buffers completed digits in a small first-word-fall-through FIFO. A parallel consumer drains the FIFO with a read strobe. Overflow is reported by a sticky flag.

---
 rtl/serial_digit_collector_if.sv | 14 +
 rtl/serial_digit_collector.sv | 77 +++++++
 tb/tb_serial_digit_collector.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/serial_digit_collector_if.sv
// serial_digit_collector_if: serial bit input and parallel FIFO read port of the digit collector
interface serial_digit_collector_if;
  logic       din;
  logic       bin;
  logic       fs;
  logic       rd;
  logic [3:0] rdata;
  logic       rerr;
  logic       empty;
  logic       full;
  logic       ovf;
  modport master (output din, bin, fs, rd, input rdata, rerr, empty, full, ovf);
  modport slave  (input din, bin, fs, rd, output rdata, rerr, empty, full, ovf);
endinterface

// File: rtl/serial_digit_collector.sv
// serial_digit_collector: assembles LSB-first 4-bit digits with error tag into a FWFT FIFO
module serial_digit_collector #(
  parameter int DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_digit_collector_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t        state, state_nx;
  logic [1:0]    cnt, cnt_nx;
  logic [2:0]    sh, sh_nx;
  logic          acc, acc_nx;
  logic          push;
  logic [4:0]    word;
  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic          ovf;
  logic          empty, full, pop, wr;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sh_nx    = sh;
    acc_nx   = acc;
    push     = 1'b0;
    word     = {acc | bus.bin, bus.din, sh};
    if (bus.fs) begin
      state_nx = SHIFT;
      cnt_nx   = 2'd1;
      sh_nx    = {2'b0, bus.din};
      acc_nx   = bus.bin;
    end else if (state == SHIFT) begin
      sh_nx  = sh | ({2'b0, bus.din} << cnt);
      acc_nx = acc | bus.bin;
      cnt_nx = cnt + 2'd1;
      if (cnt == 2'd3) begin
        push     = 1'b1;
        state_nx = IDLE;
        cnt_nx   = 2'd0;
      end
    end
  end
  assign empty = count == '0;
  assign full  = count == (AW+1)'(DEPTH);
  assign pop   = bus.rd & ~empty;
  // a push into a full FIFO survives only when the head is leaving on the same edge
  assign wr    = push & (~full | pop);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      acc   <= 1'b0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sh    <= sh_nx;
      acc   <= acc_nx;
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
      if (push & full & ~pop) ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk) if (wr) mem[wp] <= word;
  assign bus.rdata = empty ? 4'b0 : mem[rp][3:0];
  assign bus.rerr  = empty ? 1'b0 : mem[rp][4];
  assign bus.empty = empty;
  assign bus.full  = full;
  assign bus.ovf   = ovf;
endmodule

// File: tb/tb_serial_digit_collector.sv
// tb_serial_digit_collector: vector table, corner sequences and random traffic vs a queue-based model
module tb_serial_digit_collector;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  serial_digit_collector_if bus();
  serial_digit_collector #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic       fs, din, bin, rd;
    logic [3:0] rdata;
    logic       rerr, empty, full, ovf;
  } vec_t;

  logic [4:0] mq[$];
  int         nb;
  int         cur;
  logic       ce;
  logic       movf;

  task automatic model_reset();
    mq.delete();
    nb = 0;
    cur = 0;
    ce = 1'b0;
    movf = 1'b0;
  endtask

  task automatic model_step(input logic f, d, b, r);
    bit         done = 0;
    bit         popping;
    bit         was_full;
    logic [4:0] w = '0;
    if (f) begin
      nb = 1; cur = int'(d); ce = b;
    end else if (nb > 0) begin
      cur = cur + (int'(d) << nb); ce = ce | b; nb++;
      if (nb == 4) begin done = 1; w = {ce, 4'(cur)}; nb = 0; end
    end
    popping  = r && mq.size() > 0;
    was_full = mq.size() == DEPTH;
    if (popping) void'(mq.pop_front());
    if (done) begin
      if (was_full && !popping) movf = 1'b1;
      else mq.push_back(w);
    end
  endtask

  function automatic logic [7:0] model_out();
    if (mq.size() == 0) return {1'b0, 4'h0, 1'b1, 1'b0, movf};
    return {mq[0][4], mq[0][3:0], 1'b0, mq.size() == DEPTH, movf};
  endfunction

  function automatic logic [7:0] dut_out();
    return {bus.rerr, bus.rdata, bus.empty, bus.full, bus.ovf};
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic f, d, b, r);
    bus.fs = f; bus.din = d; bus.bin = b; bus.rd = r;
    @(posedge clk);
    #1;
    model_step(f, d, b, r);
  endtask

  task automatic do_reset();
    bus.fs = 0; bus.din = 0; bus.bin = 0; bus.rd = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [3:0] v, input logic rd_last);
    for (int k = 0; k < 4; k++) step(k == 0, v[k], 1'b0, rd_last && k == 3);
  endtask

  vec_t tbl[21];

  initial begin
    tbl = '{
      '{1,1,0,0, 4'h0,0,1,0,0}, '{0,1,0,0, 4'h0,0,1,0,0}, '{0,0,0,0, 4'h0,0,1,0,0},
      '{0,1,0,0, 4'hB,0,0,0,0}, '{0,0,0,1, 4'h0,0,1,0,0},
      '{1,0,0,0, 4'h0,0,1,0,0}, '{0,0,0,0, 4'h0,0,1,0,0}, '{0,1,1,0, 4'h0,0,1,0,0},
      '{0,0,0,0, 4'h4,1,0,0,0},
      '{1,1,0,0, 4'h4,1,0,0,0}, '{0,1,0,0, 4'h4,1,0,0,0}, '{0,1,0,0, 4'h4,1,0,0,0},
      '{0,0,0,1, 4'h7,0,0,0,0}, '{0,0,0,1, 4'h0,0,1,0,0},
      '{1,1,0,0, 4'h0,0,1,0,0}, '{0,1,0,0, 4'h0,0,1,0,0}, '{1,0,0,0, 4'h0,0,1,0,0},
      '{0,1,0,0, 4'h0,0,1,0,0}, '{0,1,0,0, 4'h0,0,1,0,0}, '{0,0,0,0, 4'h6,0,0,0,0},
      '{0,0,0,1, 4'h0,0,1,0,0}
    };
    do_reset();
    chk("reset_state", dut_out(), 8'b0_0000_1_0_0);
    foreach (tbl[i]) begin
      step(tbl[i].fs, tbl[i].din, tbl[i].bin, tbl[i].rd);
      chk($sformatf("vec%0d", i), dut_out(),
          {tbl[i].rerr, tbl[i].rdata, tbl[i].empty, tbl[i].full, tbl[i].ovf});
    end

    // overflow: fifth digit dropped, stored entries intact
    do_reset();
    for (int v = 1; v <= 5; v++) send(4'(v), 1'b0);
    chk("ovf_full", {7'b0, bus.full}, 8'd1);
    chk("ovf_flag", {7'b0, bus.ovf}, 8'd1);
    for (int v = 1; v <= 4; v++) begin
      chk($sformatf("ovf_read%0d", v), {4'b0, bus.rdata}, 8'(v));
      step(0, 0, 0, 1);
    end
    chk("ovf_drained", {6'b0, bus.empty, bus.ovf}, 8'b11);

    // full with push and pop on the same edge
    do_reset();
    for (int v = 1; v <= 4; v++) send(4'(v), 1'b0);
    send(4'h5, 1'b1);
    chk("pp_full_no_ovf", {6'b0, bus.full, bus.ovf}, 8'b10);
    for (int v = 2; v <= 5; v++) begin
      chk($sformatf("pp_read%0d", v), {4'b0, bus.rdata}, 8'(v));
      step(0, 0, 0, 1);
    end
    chk("pp_empty", {7'b0, bus.empty}, 8'd1);

    // asynchronous reset mid-frame clears FIFO and sticky overflow
    do_reset();
    for (int v = 1; v <= 5; v++) send(4'(v), 1'b0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {5'b0, bus.empty, bus.full, bus.ovf}, 8'b100);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) step(0, k[0], k[1], 0);
    chk("no_fs_no_push", dut_out(), 8'b0_0000_1_0_0);

    // random traffic: slow reader then fast reader
    do_reset();
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 9) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
           n < 400 ? $urandom_range(0, 7) == 0 : $urandom_range(0, 1) == 0);
      chk($sformatf("rand%0d", n), dut_out(), model_out());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
